// File: rtl/cond_check_unit_if.sv
// Request/response handshake bundle for the condition-check unit.
// master = requester/consumer side, slave = the check unit.
interface cond_check_unit_if;
  logic       req_valid;
  logic [3:0] req_cond;
  logic       req_ready;
  logic       resp_valid;
  logic       resp_pass;
  logic       resp_ready;

  modport master (output req_valid, req_cond, resp_ready,
                  input  req_ready, resp_valid, resp_pass);
  modport slave  (input  req_valid, req_cond, resp_ready,
                  output req_ready, resp_valid, resp_pass);
endinterface

// File: rtl/cond_check_unit.sv
// ARM-style condition evaluator with a status register, a one-entry response
// buffer and saturating pass/fail statistics counters.
module cond_check_unit #(
  parameter bit          FORWARD = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       sr_in,
  input  logic             s_en,
  input  logic             freeze,
  input  logic             clr_cnt,
  output logic [3:0]       sr_out,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  cond_check_unit_if.slave bus
);
  logic [3:0]       sr_q, sr_d, eff;
  logic             vld_q, vld_d, pass_q, pass_d;
  logic [CNT_W-1:0] pc_q, pc_d, fc_q, fc_d;
  logic             flag_upd, accept, cond_ok;
  logic             z, c, n, v;

  assign flag_upd = s_en & ~freeze;
  // Forwarding lets an instruction see flags committed in the same cycle.
  assign eff = (FORWARD && flag_upd) ? sr_in : sr_q;
  assign {z, c, n, v} = eff;

  always_comb begin
    cond_ok = 1'b1;
    case (bus.req_cond)
      4'b0000: cond_ok = z;
      4'b0001: cond_ok = ~z;
      4'b0010: cond_ok = c;
      4'b0011: cond_ok = ~c;
      4'b0100: cond_ok = n;
      4'b0101: cond_ok = ~n;
      4'b0110: cond_ok = v;
      4'b0111: cond_ok = ~v;
      4'b1000: cond_ok = c & ~z;
      4'b1001: cond_ok = ~c | z;
      4'b1010: cond_ok = (n == v);
      4'b1011: cond_ok = (n != v);
      4'b1100: cond_ok = ~z & (n == v);
      4'b1101: cond_ok = z | (n != v);
      default: cond_ok = 1'b1;
    endcase
  end

  assign bus.req_ready = ~freeze & (~vld_q | bus.resp_ready);
  assign accept        = bus.req_valid & bus.req_ready & ~rst;

  always_comb begin
    sr_d   = sr_q;
    vld_d  = vld_q;
    pass_d = pass_q;
    pc_d   = pc_q;
    fc_d   = fc_q;
    if (flag_upd) sr_d = sr_in;
    // A new accept overwrites a draining entry, so there is no bubble.
    if (accept) begin
      vld_d  = 1'b1;
      pass_d = cond_ok;
    end else if (bus.resp_ready) begin
      vld_d = 1'b0;
    end
    if (clr_cnt) begin
      pc_d = '0;
      fc_d = '0;
    end else if (accept) begin
      if (cond_ok) begin
        if (pc_q != {CNT_W{1'b1}}) pc_d = pc_q + 1'b1;
      end else begin
        if (fc_q != {CNT_W{1'b1}}) fc_d = fc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= 4'b0000;
      vld_q  <= 1'b0;
      pass_q <= 1'b0;
      pc_q   <= '0;
      fc_q   <= '0;
    end else begin
      sr_q   <= sr_d;
      vld_q  <= vld_d;
      pass_q <= pass_d;
      pc_q   <= pc_d;
      fc_q   <= fc_d;
    end
  end

  assign sr_out         = sr_q;
  assign bus.resp_valid = vld_q;
  assign bus.resp_pass  = pass_q;
  assign pass_cnt       = pc_q;
  assign fail_cnt       = fc_q;
endmodule

// File: tb/tb_cond_check_unit.sv
// Bench for cond_check_unit: a forwarding 16-bit-counter instance and a
// non-forwarding 4-bit-counter instance driven in lockstep against a model.
module tb_cond_check_unit;
  logic       clk = 1'b0;
  logic       rst, s_en, freeze, clr_cnt, req_valid, resp_ready;
  logic [3:0] sr_in, req_cond;
  logic [3:0] sr_a, sr_b;
  logic [15:0] pc_a, fc_a;
  logic [3:0]  pc_b, fc_b;

  int total = 0;
  int bad   = 0;

  cond_check_unit_if ifa ();
  cond_check_unit_if ifb ();

  assign ifa.req_valid  = req_valid;
  assign ifa.req_cond   = req_cond;
  assign ifa.resp_ready = resp_ready;
  assign ifb.req_valid  = req_valid;
  assign ifb.req_cond   = req_cond;
  assign ifb.resp_ready = resp_ready;

  cond_check_unit #(.FORWARD(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .sr_in(sr_in), .s_en(s_en), .freeze(freeze),
    .clr_cnt(clr_cnt), .sr_out(sr_a), .pass_cnt(pc_a), .fail_cnt(fc_a),
    .bus(ifa.slave));

  cond_check_unit #(.FORWARD(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .sr_in(sr_in), .s_en(s_en), .freeze(freeze),
    .clr_cnt(clr_cnt), .sr_out(sr_b), .pass_cnt(pc_b), .fail_cnt(fc_b),
    .bus(ifb.slave));

  always #5 clk = ~clk;

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  bit [3:0] m_sr   [2];
  bit       m_vld  [2];
  bit       m_pass [2];
  int       m_pc   [2];
  int       m_fc   [2];
  int       MAXC   [2] = '{65535, 15};
  bit       FWD    [2] = '{1'b1, 1'b0};

  // Base condition from cond[3:1]; cond[0] inverts it, except 1111 is always true.
  function automatic bit cond_holds(bit [3:0] cond, bit [3:0] f);
    bit z = f[3];
    bit c = f[2];
    bit n = f[1];
    bit v = f[0];
    bit base;
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (cond == 4'hF) return 1'b1;
    return base ^ cond[0];
  endfunction

  function automatic logic [38:0] obs(int k);
    if (k == 0)
      return {sr_a, ifa.resp_valid, ifa.resp_pass & m_vld[0], pc_a, fc_a, ifa.req_ready};
    return {sr_b, ifb.resp_valid, ifb.resp_pass & m_vld[1], 12'd0, pc_b, 12'd0, fc_b,
            ifb.req_ready};
  endfunction

  function automatic logic [38:0] expv(int k);
    bit rdy;
    rdy = !freeze && (!m_vld[k] || resp_ready);
    return {m_sr[k], m_vld[k], m_pass[k] & m_vld[k], 16'(m_pc[k]), 16'(m_fc[k]), rdy};
  endfunction

  // Advance the model on the current inputs, then clock the DUTs.
  task automatic step();
    for (int k = 0; k < 2; k++) begin
      bit rdy, acc, res;
      bit [3:0] eff;
      rdy = !freeze && (!m_vld[k] || resp_ready);
      acc = req_valid && rdy;
      eff = (FWD[k] && s_en && !freeze) ? sr_in : m_sr[k];
      res = cond_holds(req_cond, eff);
      if (rst) begin
        m_sr[k] = 0; m_vld[k] = 0; m_pass[k] = 0; m_pc[k] = 0; m_fc[k] = 0;
      end else begin
        if (s_en && !freeze) m_sr[k] = sr_in;
        if (acc) begin
          m_vld[k] = 1; m_pass[k] = res;
        end else if (resp_ready) begin
          m_vld[k] = 0;
        end
        if (clr_cnt) begin
          m_pc[k] = 0; m_fc[k] = 0;
        end else if (acc) begin
          if (res) m_pc[k] = (m_pc[k] < MAXC[k]) ? m_pc[k] + 1 : MAXC[k];
          else     m_fc[k] = (m_fc[k] < MAXC[k]) ? m_fc[k] + 1 : MAXC[k];
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; s_en = 0; freeze = 0; clr_cnt = 0;
    req_valid = 0; resp_ready = 1; sr_in = 0; req_cond = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; req_valid = 1; s_en = 1; sr_in = 4'hF;
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs(k) !== 39'h1) begin
        bad++;
        $display("FAIL reset dut%0d got=%h want=%h", k, obs(k), 39'h1);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_forward();
    idle_inputs();
    rst = 1;
    step();
    rst = 0; s_en = 1; sr_in = 4'b1000; req_valid = 1; req_cond = 4'b0000;
    step();
    total++;
    if (ifa.resp_pass !== 1'b1 || ifb.resp_pass !== 1'b0) begin
      bad++;
      $display("FAIL forward_pass got a=%b b=%b want a=1 b=0", ifa.resp_pass, ifb.resp_pass);
    end
    total++;
    if (sr_a !== 4'b1000 || sr_b !== 4'b1000) begin
      bad++;
      $display("FAIL forward_sr got a=%h b=%h want 8", sr_a, sr_b);
    end
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs(k) !== expv(k)) begin
        bad++;
        $display("FAIL forward_model dut%0d got=%h want=%h", k, obs(k), expv(k));
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    bit held;
    idle_inputs();
    resp_ready = 0; req_valid = 1; req_cond = 4'b1110;
    step();
    held = ifa.resp_pass;
    req_cond = 4'b0001;  // NE with Z=1: fails once accepted
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (ifa.req_ready !== 1'b0 || ifa.resp_valid !== 1'b1 || ifa.resp_pass !== held ||
          held !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold cyc%0d got rdy=%b vld=%b pass=%b want rdy=0 vld=1 pass=1",
                 i, ifa.req_ready, ifa.resp_valid, ifa.resp_pass);
      end
    end
    resp_ready = 1;
    step();
    total++;
    if (ifa.resp_valid !== 1'b1 || ifa.resp_pass !== 1'b0) begin
      bad++;
      $display("FAIL no_bubble got vld=%b pass=%b want vld=1 pass=0",
               ifa.resp_valid, ifa.resp_pass);
    end
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs(k) !== expv(k)) begin
        bad++;
        $display("FAIL b2b_model dut%0d got=%h want=%h", k, obs(k), expv(k));
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_freeze();
    int pc0, fc0;
    idle_inputs();
    pc0 = m_pc[0]; fc0 = m_fc[0];
    freeze = 1; s_en = 1; sr_in = 4'b0100; req_valid = 1; req_cond = 4'b1110;
    #1;
    total++;
    if (ifa.req_ready !== 1'b0 || ifb.req_ready !== 1'b0) begin
      bad++;
      $display("FAIL freeze_ready got a=%b b=%b want 0", ifa.req_ready, ifb.req_ready);
    end
    step();
    step();
    total++;
    if (sr_a !== 4'b1000 || pc_a !== 16'(pc0) || fc_a !== 16'(fc0)) begin
      bad++;
      $display("FAIL freeze_hold got sr=%h pc=%0d fc=%0d want sr=8 pc=%0d fc=%0d",
               sr_a, pc_a, fc_a, pc0, fc0);
    end
    freeze = 0;
    step();
    total++;
    if (sr_a !== 4'b0100 || pc_a !== 16'(pc0 + 1) || ifa.resp_valid !== 1'b1) begin
      bad++;
      $display("FAIL freeze_release got sr=%h pc=%0d vld=%b want sr=4 pc=%0d vld=1",
               sr_a, pc_a, ifa.resp_valid, pc0 + 1);
    end
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs(k) !== expv(k)) begin
        bad++;
        $display("FAIL freeze_model dut%0d got=%h want=%h", k, obs(k), expv(k));
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_sweep();
    idle_inputs();
    clr_cnt = 1;
    step();
    clr_cnt = 0;
    for (int s = 0; s < 16; s++) begin
      s_en = 1; sr_in = 4'(s); req_valid = 0;
      step();
      s_en = 0;
      for (int c = 0; c < 16; c++) begin
        req_valid = 1; req_cond = 4'(c);
        step();
        for (int k = 0; k < 2; k++) begin
          total++;
          if (obs(k) !== expv(k)) begin
            bad++;
            $display("FAIL sweep sr=%h cond=%h dut%0d got=%h want=%h", s, c, k, obs(k), expv(k));
          end
        end
      end
    end
    total++;
    if (32'(pc_a) + 32'(fc_a) !== 32'd256) begin
      bad++;
      $display("FAIL sweep_total got=%0d want=256", pc_a + fc_a);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_saturate();
    idle_inputs();
    clr_cnt = 1;
    step();
    clr_cnt = 0; req_valid = 1; req_cond = 4'b1110;
    for (int i = 0; i < 17; i++) step();
    total++;
    if (pc_b !== 4'd15 || pc_a !== 16'd17 || fc_b !== 4'd0) begin
      bad++;
      $display("FAIL saturate got b=%0d a=%0d fb=%0d want b=15 a=17 fb=0", pc_b, pc_a, fc_b);
    end
    clr_cnt = 1;
    step();
    total++;
    if (pc_b !== 4'd0 || pc_a !== 16'd0 || ifa.resp_valid !== 1'b1) begin
      bad++;
      $display("FAIL clr_priority got b=%0d a=%0d vld=%b want 0 0 1", pc_b, pc_a, ifa.resp_valid);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_midflight();
    idle_inputs();
    resp_ready = 0; req_valid = 1; req_cond = 4'b1110;
    step();
    rst = 1;
    step();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs(k) !== 39'h1) begin
        bad++;
        $display("FAIL reset_midflight dut%0d got=%h want=%h", k, obs(k), 39'h1);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_random();
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 59) == 0);
      freeze     = ($urandom_range(0, 4) == 0);
      s_en       = $urandom_range(0, 1);
      sr_in      = 4'($urandom);
      req_valid  = ($urandom_range(0, 3) != 0);
      req_cond   = 4'($urandom);
      resp_ready = ($urandom_range(0, 2) != 0);
      clr_cnt    = ($urandom_range(0, 39) == 0);
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== expv(k)) begin
          bad++;
          $display("FAIL random cyc%0d dut%0d got=%h want=%h", i, k, obs(k), expv(k));
        end
      end
    end
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_forward();
    test_back_to_back();
    test_freeze();
    test_sweep();
    test_saturate();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cond_check_unit.md
COND_CHECK_UNIT -- requirements
Module: cond_check_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clock port clk, reset port rst.
REQ-002 Parameter FORWARD, default 1: 1 means a same-cycle flag update is forwarded to the condition evaluation; 0 means the evaluation uses only the registered flags.
REQ-003 Parameter CNT_W, default 16: width of each statistics counter.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 sr_in  input  4  ALU status, ordered {Z,C,N,V}: bit3=Z, bit2=C, bit1=N, bit0=V.
REQ-007 s_en  input  1  commit sr_in into the status register this cycle.
REQ-008 freeze  input  1  pipeline freeze; blocks flag update and request acceptance.
REQ-009 req_valid  input  1  a condition check is requested.
REQ-010 req_cond  input  4  ARM condition field of the requesting instruction.
REQ-011 req_ready  output  1  the block can accept a request this cycle.
REQ-012 resp_valid  output  1  resp_pass holds a valid result.
REQ-013 resp_pass  output  1  1 means the condition held.
REQ-014 resp_ready  input  1  the consumer takes the response this cycle.
REQ-015 sr_out  output  4  registered status, same bit order as sr_in.
REQ-016 clr_cnt  input  1  clear both statistics counters.
REQ-017 pass_cnt, fail_cnt  output  CNT_W each  counts of accepted requests that passed and that failed.

Function
REQ-018 sr_out SHALL load sr_in on the rising edge when s_en=1 and freeze=0; otherwise sr_out holds.
REQ-019 req_ready SHALL equal ~freeze & (~resp_valid | resp_ready), combinationally.
REQ-020 A request SHALL be accepted on a cycle with req_valid & req_ready.
REQ-021 Each accepted request SHALL be evaluated against an effective flag value: sr_in when FORWARD=1 and s_en & ~freeze in the same cycle, otherwise sr_out.
REQ-022 Conditions: 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V.
REQ-023 Conditions: 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 SHALL evaluate to 1.
REQ-024 Latency SHALL be one cycle: resp_valid=1 and resp_pass are registered on the edge that ends the accepting cycle.
REQ-025 The output buffer holds one entry; resp_valid and resp_pass SHALL stay stable while resp_valid & ~resp_ready.
REQ-026 resp_valid SHALL clear on resp_ready unless a new request is accepted in the same cycle; in that case the new result replaces the old one with no bubble.
REQ-027 On acceptance, pass_cnt SHALL increment if the result passed, and fail_cnt SHALL increment otherwise.
REQ-028 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-029 clr_cnt SHALL zero both counters on the next edge and SHALL take priority over a simultaneous increment.
REQ-030 freeze SHALL NOT alter resp_valid or resp_pass, and SHALL NOT block the consumer from draining the buffer via resp_ready.

Reset
REQ-031 On an edge with rst=1, the block SHALL set sr_out=0000, resp_valid=0, resp_pass=0, pass_cnt=0 and fail_cnt=0, overriding all other inputs.
REQ-032 A pending response SHALL be discarded when rst is asserted, and no request SHALL be accepted during a cycle with rst=1.

Verification
REQ-033 Sweep all 16 req_cond values against all 16 sr_out values with resp_ready=1; resp_pass SHALL match the REQ-022/023 table, and pass_cnt+fail_cnt SHALL equal 256.
REQ-034 sr_out=0000, s_en=1, sr_in=1000, req_cond=0000 in the same cycle -> with FORWARD=1, resp_pass=1 next cycle; with FORWARD=0, resp_pass=0; in both cases sr_out=1000.
REQ-035 resp_valid=1, resp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0 and resp_pass stable; when resp_ready=1 with a request present, the new result SHALL appear on the following cycle with no gap.
REQ-036 freeze=1 with s_en=1, sr_in=0100, req_valid=1 -> sr_out unchanged, req_ready=0, no counter change; releasing freeze SHALL resume normal operation.
REQ-037 CNT_W=4: 17 passing requests -> pass_cnt=15; then clr_cnt together with an accepted request -> pass_cnt=0.
REQ-038 rst asserted while resp_valid=1 and counters are nonzero -> next cycle all outputs are 0 and req_ready=1.
